// File: rtl/i2c_rw_seq_if.sv
// i2c_rw_seq_if: transaction bus between the burst sequencer and the I2C byte controller
//   master (sequencer): drives wr_en, rd_en, i2c_start, addr_num, byte_addr, i2c_wr_data
//                       and samples i2c_end, i2c_rd_data
//   slave (controller): the mirror image
interface i2c_rw_seq_if;
  logic        wr_en;
  logic        rd_en;
  logic        i2c_start;
  logic        addr_num;
  logic [15:0] byte_addr;
  logic [7:0]  i2c_wr_data;
  logic        i2c_end;
  logic [7:0]  i2c_rd_data;
  modport master (
    output wr_en, rd_en, i2c_start, addr_num, byte_addr, i2c_wr_data,
    input  i2c_end, i2c_rd_data
  );
  modport slave (
    input  wr_en, rd_en, i2c_start, addr_num, byte_addr, i2c_wr_data,
    output i2c_end, i2c_rd_data
  );
endinterface

// File: rtl/i2c_rw_seq.sv
// i2c_rw_seq: EEPROM burst sequencer issuing byte transactions to an I2C controller, with an 8-deep read FIFO
//   i2c_clk, sys_rst         : clock and synchronous active-high reset
//   bus (master)             : per-byte transaction handshake to the I2C controller
//   write_req, read_req      : one-cycle burst requests (write wins when both)
//   base_addr, byte_num      : burst start address and length (0 ignored)
//   data_seed                : write data of byte 0; byte i carries seed + i
//   fifo_rd_en, fifo_dout    : pop port of the read FIFO
//   busy, fifo_count/empty/full : status
module i2c_rw_seq #(
  parameter logic [15:0] CNT_WAIT_MAX = 16'd5000,
  parameter logic        ADDR_NUM     = 1'b1
) (
  input  logic              i2c_clk,
  input  logic              sys_rst,
  i2c_rw_seq_if.master      bus,
  input  logic              write_req,
  input  logic              read_req,
  input  logic [15:0]       base_addr,
  input  logic [3:0]        byte_num,
  input  logic [7:0]        data_seed,
  input  logic              fifo_rd_en,
  output logic              busy,
  output logic [7:0]        fifo_dout,
  output logic [3:0]        fifo_count,
  output logic              fifo_empty,
  output logic              fifo_full
);
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_WAIT, WR_GAP, RD_REQ, RD_WAIT, RD_GAP} state_t;
  state_t      state, nxt;
  logic [15:0] base, cnt;
  logic [3:0]  num, idx;
  logic [7:0]  seed;
  logic [7:0]  mem [8];
  logic [2:0]  wp, rp;
  logic        start_wr, start_rd, tc, gap, push, pop;
  assign start_wr = write_req && byte_num != 4'd0;
  assign start_rd = read_req && byte_num != 4'd0 && !write_req;
  assign tc       = cnt == CNT_WAIT_MAX - 16'd1;
  assign gap      = state == WR_GAP || state == RD_GAP;
  assign pop      = fifo_rd_en && !fifo_empty;
  // a read started from IDLE with a full FIFO must not overwrite the oldest byte
  assign push     = state == RD_WAIT && bus.i2c_end && (!fifo_full || pop);
  always_ff @(posedge i2c_clk)
    state <= sys_rst ? IDLE : nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start_wr ? WR_REQ : start_rd ? RD_REQ : IDLE;
      WR_REQ:  nxt = WR_WAIT;
      WR_WAIT: nxt = bus.i2c_end ? WR_GAP : WR_WAIT;
      WR_GAP:  nxt = !tc ? WR_GAP : idx == num ? IDLE : WR_REQ;
      RD_REQ:  nxt = RD_WAIT;
      RD_WAIT: nxt = bus.i2c_end ? RD_GAP : RD_WAIT;
      RD_GAP:  nxt = !tc ? RD_GAP : idx == num ? IDLE : fifo_full ? RD_GAP : RD_REQ;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    bus.wr_en     = state == WR_REQ || state == WR_WAIT;
    bus.rd_en     = state == RD_REQ || state == RD_WAIT;
    bus.i2c_start = state == WR_REQ || state == RD_REQ;
    busy          = state != IDLE;
  end
  assign bus.addr_num    = ADDR_NUM;
  assign bus.byte_addr   = base + {12'd0, idx};
  assign bus.i2c_wr_data = seed + {4'd0, idx};
  assign fifo_empty      = fifo_count == 4'd0;
  assign fifo_full       = fifo_count == 4'd8;
  always_ff @(posedge i2c_clk) begin
    if (sys_rst) begin
      base <= 16'd0;
      num  <= 4'd0;
      seed <= 8'd0;
      idx  <= 4'd0;
      cnt  <= 16'd0;
    end else begin
      if (state == IDLE && (start_wr || start_rd)) begin
        base <= base_addr;
        num  <= byte_num;
        idx  <= 4'd0;
      end
      if (state == IDLE && start_wr) seed <= data_seed;
      if ((state == WR_WAIT || state == RD_WAIT) && bus.i2c_end) idx <= idx + 4'd1;
      // counter parks at terminal count while RD_GAP stalls on a full FIFO
      cnt <= (gap && nxt == state) ? (tc ? cnt : cnt + 16'd1) : 16'd0;
    end
  end
  always_ff @(posedge i2c_clk)
    if (push) mem[wp] <= bus.i2c_rd_data;
  always_ff @(posedge i2c_clk) begin
    if (sys_rst) begin
      wp         <= 3'd0;
      rp         <= 3'd0;
      fifo_count <= 4'd0;
      fifo_dout  <= 8'd0;
    end else begin
      if (push) wp <= wp + 3'd1;
      if (pop) begin
        fifo_dout <= mem[rp];
        rp        <= rp + 3'd1;
      end
      fifo_count <= fifo_count + {3'd0, push} - {3'd0, pop};
    end
  end
endmodule
